// File: rtl/vc_queue_2entry.sv
// vc_queue_2entry
// ---------------
// Two-entry FIFO queue with valid/ready handshakes on both sides. The two
// storage words form a circular buffer addressed by a 1-bit enqueue pointer
// and a 1-bit dequeue pointer. A 2-bit occupancy count tells full from empty.
//
// The queue has no bypass path, so a word written at one clock edge appears
// at the head after that edge. enq_rdy depends only on state and reset.
// deq_val and deq_bits depend only on state. Because of this, neither
// handshake side has a combinational path through to the other side.
//
// Ports
//   clk       in   1        clock, all state updates on the rising edge
//   reset     in   1        synchronous active-high reset
//   enq_val   in   1        upstream presents a valid word
//   enq_rdy   out  1        queue can accept a word this cycle
//   enq_bits  in   DATA_SZ  word to enqueue
//   deq_val   out  1        head word is valid
//   deq_rdy   in   1        downstream accepts the head word
//   deq_bits  out  DATA_SZ  head word (don't-care while deq_val is 0)
//   count     out  2        number of occupied entries, 0..2

module vc_queue_2entry #(
    parameter int DATA_SZ = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq_val,
    output logic               enq_rdy,
    input  logic [DATA_SZ-1:0] enq_bits,
    output logic               deq_val,
    input  logic               deq_rdy,
    output logic [DATA_SZ-1:0] deq_bits,
    output logic [1:0]         count
);

    logic [DATA_SZ-1:0] entry_q [2];
    logic               enqPtr_q, enqPtr_d;
    logic               deqPtr_q, deqPtr_d;
    logic [1:0]         count_q,  count_d;

    logic enqFire;
    logic deqFire;

    // Handshake outputs come from registered state and reset only.
    // Holding enq_rdy low during reset keeps words out of storage while the
    // pointers are being cleared.
    always_comb begin
        enq_rdy  = (count_q != 2'd2) && !reset;
        deq_val  = (count_q != 2'd0);
        deq_bits = entry_q[deqPtr_q];
        count    = count_q;
        enqFire  = enq_val && enq_rdy;
        deqFire  = deq_val && deq_rdy;
    end

    // Next-state pointer and count logic. Each pointer toggles when its own
    // side fires. The count stays the same when both sides fire or when
    // neither fires. When full, enq_rdy is low and enqFire cannot be set.
    // When empty, deq_val is low and deqFire cannot be set. So the count
    // stays within 0..2.
    always_comb begin
        enqPtr_d = enqPtr_q;
        deqPtr_d = deqPtr_q;
        count_d  = count_q;
        if (enqFire) begin
            enqPtr_d = ~enqPtr_q;
        end
        if (deqFire) begin
            deqPtr_d = ~deqPtr_q;
        end
        if (enqFire && !deqFire) begin
            count_d = count_q + 2'd1;
        end else if (deqFire && !enqFire) begin
            count_d = count_q - 2'd1;
        end
    end

    // Control state register. Reset clears occupancy and both pointers,
    // which discards any words still held in storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            enqPtr_q <= 1'b0;
            deqPtr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            enqPtr_q <= enqPtr_d;
            deqPtr_q <= deqPtr_d;
            count_q  <= count_d;
        end
    end

    // Data storage is not reset. The count decides which entries are
    // meaningful. enqFire is already gated by reset, through enq_rdy.
    always_ff @(posedge clk) begin
        if (enqFire) begin
            entry_q[enqPtr_q] <= enq_bits;
        end
    end

endmodule

// File: tb/tb_vc_queue_2entry.sv
// tb_vc_queue_2entry
// ------------------
// Directed bench for vc_queue_2entry. Each table row describes one clock
// cycle. The row holds the inputs driven in that cycle and the outputs
// expected before the next rising edge. A hand-written streaming sequence
// then checks ordering across pointer wrap-around.

module tb_vc_queue_2entry;

    logic        clk;
    logic        reset;
    logic        enq_val;
    logic        enq_rdy;
    logic [31:0] enq_bits;
    logic        deq_val;
    logic        deq_rdy;
    logic [31:0] deq_bits;
    logic [1:0]  count;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic        rst;
        logic        ev;
        logic [31:0] eb;
        logic        dr;
        logic        expRdy;
        logic        expVal;
        logic [31:0] expBits;
        logic [1:0]  expCnt;
        logic        chkState;
        logic        chkBits;
    } vec_t;

    vec_t vecs[$];

    vc_queue_2entry #(.DATA_SZ(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .enq_val  (enq_val),
        .enq_rdy  (enq_rdy),
        .enq_bits (enq_bits),
        .deq_val  (deq_val),
        .deq_rdy  (deq_rdy),
        .deq_bits (deq_bits),
        .count    (count)
    );

    // Free-running clock with a 10-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build one table row
    function automatic vec_t mk(input logic rst, input logic ev, input logic [31:0] eb,
                                input logic dr, input logic expRdy, input logic expVal,
                                input logic [31:0] expBits, input logic [1:0] expCnt,
                                input logic chkState, input logic chkBits);
        vec_t v;
        v.rst      = rst;
        v.ev       = ev;
        v.eb       = eb;
        v.dr       = dr;
        v.expRdy   = expRdy;
        v.expVal   = expVal;
        v.expBits  = expBits;
        v.expCnt   = expCnt;
        v.chkState = chkState;
        v.chkBits  = chkBits;
        return v;
    endfunction

    // Drive one cycle's inputs, just after a falling edge
    task automatic applyStimulus(input logic rst, input logic ev, input logic [31:0] eb,
                                 input logic dr);
        @(negedge clk);
        reset    = rst;
        enq_val  = ev;
        enq_bits = eb;
        deq_rdy  = dr;
        #1;
    endtask

    // Compare one observed value with its expected value
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Main sequence. The table is filled first and then replayed. After it,
    // the streaming sequence runs.
    initial begin
        reset    = 1'b1;
        enq_val  = 1'b0;
        enq_bits = 32'h0;
        deq_rdy  = 1'b0;

        //               rst ev  eb     dr  rdy val bits   cnt chkS chkB
        // Reset held for two cycles, then idle
        vecs.push_back(mk(1, 0, 32'h0,  0,  0,  0, 32'h0,  0,  0,  0));
        vecs.push_back(mk(1, 0, 32'h0,  0,  0,  0, 32'h0,  0,  1,  0));
        vecs.push_back(mk(0, 0, 32'h0,  0,  1,  0, 32'h0,  0,  1,  0));
        // Single word, with no bypass while it is being presented
        vecs.push_back(mk(0, 1, 32'hA5, 0,  1,  0, 32'h0,  0,  1,  0));
        vecs.push_back(mk(0, 0, 32'h0,  0,  1,  1, 32'hA5, 1,  1,  1));
        vecs.push_back(mk(0, 0, 32'h0,  1,  1,  1, 32'hA5, 1,  1,  1));
        vecs.push_back(mk(0, 0, 32'h0,  0,  1,  0, 32'h0,  0,  1,  0));
        // Fill and backpressure. 0x44 is offered while full and must be dropped.
        vecs.push_back(mk(0, 1, 32'h11, 0,  1,  0, 32'h0,  0,  1,  0));
        vecs.push_back(mk(0, 1, 32'h22, 0,  1,  1, 32'h11, 1,  1,  1));
        vecs.push_back(mk(0, 1, 32'h33, 0,  0,  1, 32'h11, 2,  1,  1));
        vecs.push_back(mk(0, 1, 32'h33, 0,  0,  1, 32'h11, 2,  1,  1));
        vecs.push_back(mk(0, 1, 32'h44, 1,  0,  1, 32'h11, 2,  1,  1));
        vecs.push_back(mk(0, 0, 32'h0,  1,  1,  1, 32'h22, 1,  1,  1));
        vecs.push_back(mk(0, 1, 32'h33, 0,  1,  0, 32'h0,  0,  1,  0));
        vecs.push_back(mk(0, 0, 32'h0,  1,  1,  1, 32'h33, 1,  1,  1));
        vecs.push_back(mk(0, 0, 32'h0,  0,  1,  0, 32'h0,  0,  1,  0));
        // Simultaneous enqueue and dequeue at count 1
        vecs.push_back(mk(0, 1, 32'h11, 0,  1,  0, 32'h0,  0,  1,  0));
        vecs.push_back(mk(0, 1, 32'h22, 1,  1,  1, 32'h11, 1,  1,  1));
        vecs.push_back(mk(0, 0, 32'h0,  0,  1,  1, 32'h22, 1,  1,  1));
        vecs.push_back(mk(0, 0, 32'h0,  1,  1,  1, 32'h22, 1,  1,  1));
        vecs.push_back(mk(0, 0, 32'h0,  0,  1,  0, 32'h0,  0,  1,  0));
        // Dequeue request while empty is ignored
        vecs.push_back(mk(0, 0, 32'h0,  1,  1,  0, 32'h0,  0,  1,  0));
        vecs.push_back(mk(0, 0, 32'h0,  0,  1,  0, 32'h0,  0,  1,  0));
        // Reset while full discards contents. 0xDD offered during reset is dropped.
        vecs.push_back(mk(0, 1, 32'hAA, 0,  1,  0, 32'h0,  0,  1,  0));
        vecs.push_back(mk(0, 1, 32'hBB, 0,  1,  1, 32'hAA, 1,  1,  1));
        vecs.push_back(mk(1, 1, 32'hDD, 0,  0,  1, 32'hAA, 2,  1,  1));
        vecs.push_back(mk(0, 1, 32'hCC, 0,  1,  0, 32'h0,  0,  1,  0));
        vecs.push_back(mk(0, 0, 32'h0,  0,  1,  1, 32'hCC, 1,  1,  1));
        vecs.push_back(mk(0, 0, 32'h0,  1,  1,  1, 32'hCC, 1,  1,  1));
        vecs.push_back(mk(0, 0, 32'h0,  0,  1,  0, 32'h0,  0,  1,  0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].ev, vecs[i].eb, vecs[i].dr);
            checkOutput($sformatf("v%0d enq_rdy", i), {31'b0, enq_rdy}, {31'b0, vecs[i].expRdy});
            if (vecs[i].chkState) begin
                checkOutput($sformatf("v%0d deq_val", i), {31'b0, deq_val}, {31'b0, vecs[i].expVal});
                checkOutput($sformatf("v%0d count", i), {30'b0, count}, {30'b0, vecs[i].expCnt});
            end
            if (vecs[i].chkBits) begin
                checkOutput($sformatf("v%0d deq_bits", i), deq_bits, vecs[i].expBits);
            end
        end

        // Continuous stream of 0x1..0x8 with both sides always willing.
        // Word k is at the head in cycle k, and the count stays at most 1.
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) begin
                applyStimulus(1'b0, 1'b1, 32'(k + 1), 1'b1);
            end else begin
                applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            end
            checkOutput($sformatf("stream%0d count_le1", k), {31'b0, (count <= 2'd1)}, 32'd1);
            if (k == 0) begin
                checkOutput("stream0 deq_val", {31'b0, deq_val}, 32'd0);
            end else begin
                checkOutput($sformatf("stream%0d deq_val", k), {31'b0, deq_val}, 32'd1);
                checkOutput($sformatf("stream%0d deq_bits", k), deq_bits, 32'(k));
            end
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("stream_end count", {30'b0, count}, 32'd0);
        checkOutput("stream_end deq_val", {31'b0, deq_val}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/vc_queue_2entry.md
VC_QUEUE_2ENTRY -- requirements
Module: vc_queue_2entry

Interface
REQ-001 Parameter: DATA_SZ, default 32, width of each queued data word.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- enq_val  input  1  upstream presents a valid word.
- enq_rdy  output  1  queue can accept a word.
- enq_bits  input  DATA_SZ  word to enqueue.
- deq_val  output  1  queue presents a valid head word.
- deq_rdy  input  1  downstream accepts the head word.
- deq_bits  output  DATA_SZ  head word.
- count  output  2  number of occupied entries, 0..2.

Function
REQ-003 The enqueue SHALL fire in a cycle where enq_val && enq_rdy are both 1 at the rising edge; the dequeue SHALL fire where deq_val && deq_rdy are both 1.
REQ-004 Storage SHALL be two DATA_SZ entries, managed as a circular buffer: 1-bit enq_ptr, 1-bit deq_ptr, 2-bit count.
REQ-005 enq_rdy SHALL be (count != 2) && !reset, driven only from state and reset; there SHALL be no combinational path from deq_rdy to enq_rdy.
REQ-006 deq_val SHALL be (count != 0), driven only from state; there SHALL be no combinational path from enq_val or enq_bits to deq_val or deq_bits.
REQ-007 deq_bits SHALL equal the entry at deq_ptr; when deq_val is 0, the deq_bits value is don't-care.
REQ-008 Latency SHALL be exactly one cycle: a word enqueued at edge N is visible on deq_bits with deq_val=1 after edge N, and not earlier (no bypass).
REQ-009 On enqueue: entry[enq_ptr] <= enq_bits, and enq_ptr SHALL toggle (wrap 1->0).
REQ-010 On dequeue: deq_ptr SHALL toggle (wrap 1->0).
REQ-011 count SHALL update per edge as follows:
- +1 on enqueue only.
- -1 on dequeue only.
- unchanged on simultaneous enqueue and dequeue, or on neither.
REQ-012 Simultaneous enqueue and dequeue at count=1: the old head leaves, the new word becomes head next cycle, and count stays 1.
REQ-013 Full (count=2): enq_rdy=0, so no enqueue occurs even if deq fires the same edge; enq_rdy returns to 1 in the cycle after the dequeue.
REQ-014 Empty (count=0): deq_val=0, and deq_rdy SHALL be ignored; no pointer or count change occurs from the dequeue side.
REQ-015 Data ordering SHALL be strictly FIFO across pointer wrap-around, for unbounded sequences.
REQ-016 count SHALL never exceed 2 or underflow below 0 under any input combination.

Reset
REQ-017 When reset=1 at a rising edge, the next state SHALL be count=0, enq_ptr=0, deq_ptr=0; storage entries are not reset.
REQ-018 While reset=1: enq_rdy=0 and no enqueue SHALL occur; after reset, deq_val=0 and count=0 outputs follow.
REQ-019 Reset asserted mid-operation (count 1 or 2) SHALL discard all contents; no stale word SHALL appear on deq after reset deasserts.
REQ-020 The first enqueue SHALL be accepted in the first cycle with reset=0.

Verification
REQ-021 Reset then idle: reset=1 for 2 cycles -> enq_rdy=0 during reset; after reset, count=0, deq_val=0, enq_rdy=1.
REQ-022 Single word: enq 0x0000_00A5 at edge N with deq_rdy=0 -> after N, deq_val=1, deq_bits=0x0000_00A5, count=1; deq_rdy=1 at N+1 -> count=0, deq_val=0.
REQ-023 Fill and backpressure: enq 0x11 then 0x22 with deq_rdy=0 -> count=2, enq_rdy=0; hold enq_val=1 with 0x33 -> not accepted; dequeue yields 0x11, then 0x22, then 0x33.
REQ-024 Simultaneous at count=1: head 0x11, enq 0x22 with deq_rdy=1 -> count stays 1, deq_bits=0x22 next cycle.
REQ-025 Wrap/stream: enq_val=1 and deq_rdy=1 continuously, with 8 words 0x1..0x8 -> output order 0x1..0x8, one per cycle after the first; count never exceeds 1.
REQ-026 Mid-operation reset: count=2 holding 0xAA and 0xBB, reset=1 for one cycle -> count=0, deq_val=0; next enq 0xCC -> deq_bits=0xCC.
